// File: rtl/meas_result_buf_pkg.sv
// Shared record layout for measurement results and a saturating-increment helper.
// The host-side unpacker and the bench decode rd_data using the offsets defined here.
package meas_result_buf_pkg;

  localparam int XACC_LSB = 0;
  localparam int YACC_LSB = 32;
  localparam int TAG_LSB  = 64;
  localparam int DEF_TAGW = 8;

  function automatic int rx_bit(input int tagw);
    return 64 + tagw;
  endfunction

  function automatic int ry_bit(input int tagw);
    return 65 + tagw;
  endfunction

  localparam int RX_BIT = 64 + DEF_TAGW;
  localparam int RY_BIT = 65 + DEF_TAGW;

  // Increments v and clamps the result at 2^w-1, so a w-bit counter never wraps.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/meas_result_buf_fwft_fifo.sv
// First-word-fall-through FIFO. dout is a register that holds the head entry,
// and the array holds the entries queued behind it. Writes and reads follow
// strict valid/ready rules: a read happens only when valid & rd are both high,
// and a write is taken when wr is high and the FIFO is not full, or is full
// but is being read in the same cycle.
module fwft_fifo
  import meas_result_buf_pkg::*;
#(
  parameter  int dw    = 74,
  parameter  int depth = 16,
  localparam int dl    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic [dw-1:0] din,
  input  logic          wr,
  output logic          full,
  output logic [dw-1:0] dout,
  output logic          valid,
  input  logic          rd,
  output logic [dl:0]   level
);

  logic [dw-1:0] mem_q [depth];
  logic [dw-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic [dl-1:0] wr_ptr_q, wr_ptr_d;
  logic [dl-1:0] rd_ptr_q, rd_ptr_d;
  logic [dl:0]   level_q, level_d;
  logic          mem_we;
  logic          rd_eff;
  logic          wr_eff;
  logic          stored_empty;

  assign full         = (level_q == (dl+1)'(depth));
  assign rd_eff       = rd & valid_q;
  assign wr_eff       = wr & (~full | rd_eff);
  // Nothing waits behind the head register when at most one entry is held.
  assign stored_empty = (level_q <= (dl+1)'(1));

  always_comb begin
    dout_d   = dout_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_we   = 1'b0;
    if (clr) begin
      dout_d   = '0;
      valid_d  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      case ({wr_eff, rd_eff})
        2'b10: begin
          if (!valid_q) begin
            dout_d  = din;
            valid_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + dl'(1);
          end
          level_d = level_q + (dl+1)'(1);
        end
        2'b01: begin
          if (stored_empty) begin
            valid_d = 1'b0;
          end else begin
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + dl'(1);
          end
          level_d = level_q - (dl+1)'(1);
        end
        2'b11: begin
          if (stored_empty) begin
            dout_d = din;
          end else begin
            dout_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + dl'(1);
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + dl'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q   <= '0;
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // The storage array has no reset. Every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign level = level_q;

endmodule

// File: rtl/meas_result_buf.sv
// Measurement result buffer. It captures one record per done strobe into a
// FWFT FIFO and keeps saturating counts of shots, ones and dropped records.
module meas_result_buf
  import meas_result_buf_pkg::*;
#(
  parameter  int depth = 16,
  parameter  int tagw  = 8,
  parameter  int cntw  = 32,
  localparam int dl    = $clog2(depth),
  localparam int recw  = 2 + tagw + 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            done,
  input  logic            resultx,
  input  logic            resulty,
  input  logic [31:0]     xacc,
  input  logic [31:0]     yacc,
  input  logic [tagw-1:0] tag,
  input  logic            clear,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [recw-1:0] rd_data,
  output logic [dl:0]     level,
  output logic [cntw-1:0] shots,
  output logic [cntw-1:0] ones,
  output logic [cntw-1:0] drops,
  output logic            overflow
);

  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [recw-1:0] rec;
  logic [cntw-1:0] shots_q, shots_d;
  logic [cntw-1:0] ones_q, ones_d;
  logic [cntw-1:0] drops_q, drops_d;
  logic            overflow_q, overflow_d;

  assign rec  = {resulty, resultx, tag, yacc, xacc};
  assign pop  = rd_valid & rd_ready;
  // clear has priority, so a done in the same cycle is neither stored nor counted.
  assign push = done & ~clear & (~full | pop);
  assign drop = done & ~clear & full & ~pop;

  fwft_fifo #(
    .dw    (recw),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .din     (rec),
    .wr      (push),
    .full    (full),
    .dout    (rd_data),
    .valid   (rd_valid),
    .rd      (rd_ready),
    .level   (level)
  );

  always_comb begin
    shots_d    = shots_q;
    ones_d     = ones_q;
    drops_d    = drops_q;
    overflow_d = overflow_q;
    if (clear) begin
      shots_d    = '0;
      ones_d     = '0;
      drops_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        shots_d = cntw'(sat_inc(64'(shots_q), cntw));
        if (resultx) ones_d = cntw'(sat_inc(64'(ones_q), cntw));
      end
      if (drop) begin
        drops_d    = cntw'(sat_inc(64'(drops_q), cntw));
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shots_q    <= '0;
      ones_q     <= '0;
      drops_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      shots_q    <= shots_d;
      ones_q     <= ones_d;
      drops_q    <= drops_d;
      overflow_q <= overflow_d;
    end
  end

  assign shots    = shots_q;
  assign ones     = ones_q;
  assign drops    = drops_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_meas_result_buf.sv
// Directed bench for meas_result_buf. Inputs are driven, and outputs checked,
// 1 time unit after each rising clock edge.
module tb_meas_result_buf;
  import meas_result_buf_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAGW  = 8;
  localparam int CNTW  = 32;
  localparam int DL    = $clog2(DEPTH);
  localparam int RECW  = 2 + TAGW + 64;

  logic            clk;
  logic            reset_n;
  logic            done;
  logic            resultx;
  logic            resulty;
  logic [31:0]     xacc;
  logic [31:0]     yacc;
  logic [TAGW-1:0] tag;
  logic            clear;
  logic            rd_valid;
  logic            rd_ready;
  logic [RECW-1:0] rd_data;
  logic [DL:0]     level;
  logic [CNTW-1:0] shots;
  logic [CNTW-1:0] ones;
  logic [CNTW-1:0] drops;
  logic            overflow;

  int n_total = 0;
  int n_pass  = 0;

  meas_result_buf #(
    .depth (DEPTH),
    .tagw  (TAGW),
    .cntw  (CNTW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .done     (done),
    .resultx  (resultx),
    .resulty  (resulty),
    .xacc     (xacc),
    .yacc     (yacc),
    .tag      (tag),
    .clear    (clear),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .shots    (shots),
    .ones     (ones),
    .drops    (drops),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
  endtask

  function automatic logic [RECW-1:0] mk_rec(input logic [31:0] x, input logic [31:0] y,
                                             input logic [TAGW-1:0] t, input logic rx,
                                             input logic ry);
    logic [RECW-1:0] r;
    r = '0;
    r[XACC_LSB +: 32]  = x;
    r[YACC_LSB +: 32]  = y;
    r[TAG_LSB +: TAGW] = t;
    r[RX_BIT]          = rx;
    r[RY_BIT]          = ry;
    return r;
  endfunction

  task automatic set_done(input logic [TAGW-1:0] t, input logic [31:0] x, input logic [31:0] y,
                          input logic rx, input logic ry);
    done    = 1'b1;
    tag     = t;
    xacc    = x;
    yacc    = y;
    resultx = rx;
    resulty = ry;
  endtask

  initial begin
    logic [31:0] iv;
    reset_n  = 1'b0;
    done     = 1'b0;
    resultx  = 1'b0;
    resulty  = 1'b0;
    xacc     = '0;
    yacc     = '0;
    tag      = '0;
    clear    = 1'b0;
    rd_ready = 1'b0;

    // Reset values
    #12;
    chk("reset_rd_valid", 128'(rd_valid), 128'(0));
    chk("reset_rd_data",  128'(rd_data),  128'(0));
    chk("reset_level",    128'(level),    128'(0));
    chk("reset_counters", 128'({shots, ones, drops}), 128'(0));
    chk("reset_overflow", 128'(overflow), 128'(0));
    #10 reset_n = 1'b1;
    tick();

    // Single shot: the record is visible one cycle after done
    set_done(8'h05, 32'h0000_1234, 32'hFFFF_FF00, 1'b1, 1'b0);
    tick();
    done = 1'b0;
    chk("single_rd_valid", 128'(rd_valid), 128'(1));
    chk("single_rd_data",  128'(rd_data),
        128'(mk_rec(32'h0000_1234, 32'hFFFF_FF00, 8'h05, 1'b1, 1'b0)));
    chk("single_level", 128'(level), 128'(1));
    chk("single_shots", 128'(shots), 128'(1));
    chk("single_ones",  128'(ones),  128'(1));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("single_pop_valid", 128'(rd_valid), 128'(0));
    chk("single_pop_level", 128'(level),    128'(0));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear0_shots", 128'(shots), 128'(0));

    // Backpressure: 20 records into a 16-deep FIFO with no reads
    for (int i = 0; i < 20; i++) begin
      iv = 32'(i);
      set_done(8'(i), iv, ~iv, iv[0], iv[1]);
      tick();
    end
    done = 1'b0;
    chk("bp_level",    128'(level),    128'(16));
    chk("bp_drops",    128'(drops),    128'(4));
    chk("bp_overflow", 128'(overflow), 128'(1));
    chk("bp_shots",    128'(shots),    128'(16));
    chk("bp_ones",     128'(ones),     128'(8));
    chk("bp_head",     128'(rd_data),  128'(mk_rec(32'd0, ~32'd0, 8'd0, 1'b0, 1'b0)));

    // Full FIFO with a push and a pop in the same cycle
    set_done(8'hA0, 32'h0000_A0A0, 32'h0A0A_0000, 1'b1, 1'b0);
    rd_ready = 1'b1;
    tick();
    done     = 1'b0;
    rd_ready = 1'b0;
    chk("fullpop_drops", 128'(drops), 128'(4));
    chk("fullpop_level", 128'(level), 128'(16));
    chk("fullpop_shots", 128'(shots), 128'(17));
    chk("fullpop_ones",  128'(ones),  128'(9));

    // Stall: head must hold steady while done keeps arriving
    for (int k = 0; k < 10; k++) begin
      set_done(8'(8'hB0 + k), 32'hDEAD_0000, 32'hBEEF_0000, 1'b1, 1'b1);
      tick();
      chk("stall_rd_data", 128'(rd_data), 128'(mk_rec(32'd1, ~32'd1, 8'd1, 1'b1, 1'b0)));
    end
    done = 1'b0;
    chk("stall_valid", 128'(rd_valid), 128'(1));
    chk("stall_drops", 128'(drops),    128'(14));
    chk("stall_shots", 128'(shots),    128'(17));

    // Drain: tags 1..15 come out in order, then A0
    rd_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      chk("drain_valid", 128'(rd_valid), 128'(1));
      chk("drain_tag",   128'(rd_data[TAG_LSB +: TAGW]), 128'(i));
      tick();
    end
    chk("drain_last", 128'(rd_data), 128'(mk_rec(32'h0000_A0A0, 32'h0A0A_0000, 8'hA0, 1'b1, 1'b0)));
    tick();
    rd_ready = 1'b0;
    chk("drain_empty_valid", 128'(rd_valid), 128'(0));
    chk("drain_empty_level", 128'(level),    128'(0));

    // Push and pop at level 1: the head is replaced
    set_done(8'h33, 32'h3333, 32'h3030, 1'b0, 1'b1);
    tick();
    set_done(8'h44, 32'h4444, 32'h4040, 1'b1, 1'b1);
    rd_ready = 1'b1;
    tick();
    done     = 1'b0;
    rd_ready = 1'b0;
    chk("l1_valid", 128'(rd_valid), 128'(1));
    chk("l1_data",  128'(rd_data),  128'(mk_rec(32'h4444, 32'h4040, 8'h44, 1'b1, 1'b1)));
    chk("l1_level", 128'(level),    128'(1));

    // Clear together with done
    set_done(8'h55, 32'h5555, 32'h5050, 1'b1, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    done  = 1'b0;
    chk("clr_level",    128'(level),    128'(0));
    chk("clr_valid",    128'(rd_valid), 128'(0));
    chk("clr_counters", 128'({shots, ones, drops}), 128'(0));
    chk("clr_overflow", 128'(overflow), 128'(0));
    tick();
    chk("clr_after_level", 128'(level), 128'(0));
    chk("clr_after_shots", 128'(shots), 128'(0));

    // Asynchronous reset in the middle of a burst, away from a clock edge
    for (int i = 0; i < 3; i++) begin
      set_done(8'(8'h60 + i), 32'(i), 32'(i), 1'b1, 1'b0);
      tick();
    end
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid",    128'(rd_valid), 128'(0));
    chk("arst_rd_data",  128'(rd_data),  128'(0));
    chk("arst_level",    128'(level),    128'(0));
    chk("arst_counters", 128'({shots, ones}), 128'(0));
    done = 1'b0;
    #7 reset_n = 1'b1;
    tick();
    set_done(8'h77, 32'h7777, 32'h7070, 1'b0, 1'b0);
    tick();
    done = 1'b0;
    chk("post_rst_shots", 128'(shots), 128'(1));
    chk("post_rst_ones",  128'(ones),  128'(0));
    chk("post_rst_level", 128'(level), 128'(1));
    chk("post_rst_data",  128'(rd_data), 128'(mk_rec(32'h7777, 32'h7070, 8'h77, 1'b0, 1'b0)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/meas_result_buf.md
Name: meas_result_buf

Overview:
- Downstream consumer of the per-qubit measurement/discrimination stage.
- Captures one record on every `done` strobe: rotated accumulator `xacc`/`yacc`, the discriminated bits `resultx`/`resulty`, and a shot tag.
- Queues records in a first-word-fall-through (FWFT) FIFO with a valid/ready read port toward the host/DMA side.
- Keeps statistics: shot count, "1"-result count, dropped-record count.

Parameters:
- depth, 16, FIFO entries; power of 2, ≥2.
- tagw, 8, shot tag width.
- cntw, 32, statistics counter width.
- Derived (do not override): dl = $clog2(depth); recw = 2 + tagw + 64.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- done  in  1  one-cycle strobe: result/acc valid this cycle
- resultx  in  1  discriminated bit, x axis
- resulty  in  1  discriminated bit, y axis
- xacc  in  32  signed rotated x accumulator
- yacc  in  32  signed rotated y accumulator
- tag  in  tagw  shot identifier, sampled with done
- clear  in  1  sync pulse: flush FIFO, zero counters and sticky flag
- rd_valid  out  1  head record available
- rd_ready  in  1  consumer accepts head
- rd_data  out  recw  {resulty, resultx, tag, yacc, xacc}, MSB→LSB
- level  out  dl+1  occupied entries
- shots  out  cntw  records accepted
- ones  out  cntw  accepted records with resultx=1
- drops  out  cntw  records lost to full FIFO
- overflow  out  1  sticky: ≥1 drop since last clear/reset

Behaviour:
- Reset (reset_n low, async): FIFO empty; rd_valid=0, rd_data=0, level=0; shots, ones, drops = 0; overflow=0.
- Push/pop:
  - push = done & (~full | pop); pop = rd_valid & rd_ready.
  - Full and pop in the same cycle: the new record is accepted; level unchanged.
  - Empty and push: record appears at rd_data with rd_valid=1 on the next cycle (latency 1). No same-cycle bypass.
  - Push and pop when level=1: head is replaced by the new record next cycle; rd_valid stays 1.
- rd_data is held stable while rd_valid & ~rd_ready (AXI-stream rule). rd_valid never drops without a pop or clear.
- level = entries written − entries popped, range 0..depth. full = (level==depth).
- Pointers are dl-bit and wrap modulo depth. Full/empty come from level, not pointer compare.
- Drop: done & full & ~pop → record discarded; drops += 1 (saturating at all-ones); overflow ← 1.
- Counters update one cycle after the accepted done:
  - shots += 1;
  - ones += resultx.
  - Both saturate at 2^cntw−1 and never wrap.
- clear (highest priority, synchronous):
  - next cycle: level=0, rd_valid=0, all counters 0, overflow=0;
  - any done in the clear cycle is discarded and not counted.
- done asserted on consecutive cycles: each cycle is an independent record. Throughput is 1 record/clk.
- Reset mid-operation discards contents immediately; outputs are at reset values while reset_n=0.
- No state machine beyond FIFO control. Output register holds the head (FWFT); storage is a depth-entry register/LUT array.

Decomposition:
- Shared package: record field offsets (XACC_LSB=0, YACC_LSB=32, TAG_LSB=64, RX_BIT=64+tagw, RY_BIT=65+tagw) and a saturating-increment function. Shared so the host-side unpacker and the bench use the same layout.
- One sub-module: fwft_fifo (params dw, depth). Ports: clk, reset_n, clr, din, wr, full, dout, valid, rd, level.
- meas_result_buf contains the push gating, statistics counters and the overflow flag.

Test Plan:
- Single shot: reset, then done=1 with xacc=32'h0000_1234, yacc=32'hFFFF_FF00, resultx=1, resulty=0, tag=8'h05 → next cycle rd_valid=1, rd_data matches these fields, level=1, shots=1, ones=1.
- Backpressure: rd_ready=0, 20 consecutive done (depth 16) → level=16, drops=4, overflow=1, shots=16. Then rd_ready=1 → 16 records pop in tag order 0..15 and rd_valid falls.
- Full plus simultaneous pop: FIFO full, done and rd_ready asserted in the same cycle → drops unchanged, level stays 16, new tag at the tail.
- Stall stability: rd_valid=1, rd_ready=0 for 10 cycles while pushes continue → rd_data constant throughout.
- Clear: clear pulse together with done → next cycle level=0, rd_valid=0, shots=ones=drops=0, overflow=0; that done is not recorded.
- Async reset: deassert reset_n mid-burst, off a clock edge → outputs zero immediately. After release, the first done yields shots=1.
